delta_seq: RTL and testbench
============================

// Module: delta_seq
// PURPOSE
//  Parametrised, handshaked LSTM back-prop delta engine for one cell per transaction. It computes
//  dstate, d_a, d_i, d_f and d_o on a single shared saturating multiplier plus one add/sub, sequenced by an FSM.
//  Successor to the hand-sequenced delta datapath: adds width/format parameters, output- vs hidden-layer
//  mode, dstate carry-in, valid/ready handshake and saturation flagging.
//  Sits between the forward-pass state memory and the weight-gradient accumulator.
// PARAMETERS
//  WIDTH  32  signed fixed-point word width, two's complement
//  FRAC   24  fraction bits; ONE = 1<<FRAC (Q8.24 at defaults)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous active-high reset
//  i_valid    in   1      operand set valid
//  o_ready    out  1      engine can accept (IDLE or DONE)
//  i_last     in   1      1: output layer, Dout=h-t; 0: hidden, Dout=i_d_out
//  i_at,i_it,i_ft,i_ot in WIDTH  gate activations at time t
//  i_tanh_s   in   WIDTH  tanh(state_t), from upstream tanh unit
//  i_c_prev   in   WIDTH  state_{t-1}
//  i_h,i_t    in   WIDTH  output and label (used when i_last=1)
//  i_d_out    in   WIDTH  Dout from upper layer (used when i_last=0)
//  i_ds_next,i_f_next in WIDTH  dstate_{t+1}, f_{t+1} (0 at last timestep)
//  o_valid    out  1      result valid, one-cycle pulse
//  o_d_state,o_d_a,o_d_i,o_d_f,o_d_o out WIDTH  deltas
//  o_sat      out  1      any op in this transaction saturated
// BEHAVIOUR
//  - Reset: FSM=IDLE, o_ready=1, o_valid=0, all deltas=0, o_sat=0, operand/scratch regs=0.
//  - Accept on rising edge with i_valid&&o_ready; all inputs captured into operand regs then;
//    inputs are don't-care afterwards. i_valid while busy is ignored (no queuing).
//  - FSM: IDLE -> RUN(steps 1..16, counter) -> DONE -> IDLE. Accept in IDLE or DONE goes to RUN step 1.
//  - o_valid=1 and outputs updated exactly 17 cycles after the accepting edge. Outputs hold until the next DONE.
//    Back-to-back throughput: 1 transaction / 17 cycles.
//  - mul(a,b): full 2*WIDTH signed product, arithmetic >>FRAC (truncate toward -inf),
//    saturate to [0x80..0, 0x7F..F]. add/sub: WIDTH+1 exact, then saturate. Any clamp sets o_sat.
//  - Per step, at most one mul and one add/sub; results registered:
//    1: A=i_last?h-t:d_out; M1=tanh*tanh      2: M2=A*ot; B=ONE-M1
//    3: M3=M2*B                               4: M4=ds_next*f_next
//    5: DS=M3+M4; M5=A*tanh                   6: M6=at*at; C=ONE-ot
//    7: M7=M5*ot; D=ONE-M6                    8: d_o=M7*C; E=ONE-it
//    9: M8=DS*it; F=ONE-ft                    10: d_a=M8*D
//    11: M10=DS*at   12: M11=M10*it   13: d_i=M11*E   14: M12=DS*c_prev
//    15: M13=M12*ft  16: d_f=M13*F    then DONE: o_d_state=DS, publish all and o_sat.
//  - o_sat clears on each accept; sticky within a transaction.
//  - rst mid-transaction aborts: next cycle identical to post-reset, no o_valid.
//  - i_last is sampled only at accept. Changing i_last mid-run has no effect.
// TESTING (Q8.24; 1.0=0x01000000)
//  1 Reset then idle: o_ready=1, o_valid=0, all outputs 0 for 20 cycles.
//  2 i_last=1, h=0.75, t=1.0, tanh=at=it=ft=ot=0.5, c_prev=1.0, ds_next=f_next=0
//    -> 17 cycles later: o_d_state=0xFFE80000, o_d_o=0xFFF80000, o_d_a=0xFFF70000,
//       o_d_i=0xFFFD0000, o_d_f=0xFFFA0000, o_sat=0.
//  3 i_last=0, d_out=64.0 (0x40000000), ot=1.0, tanh=0, ds_next=f_next=64.0
//    -> o_d_state=0x7FFFFFFF, o_sat=1.
//  4 i_valid held high continuously, two operand sets -> o_valid pulses at +17 and +34 cycles.
//    2nd result independent of 1st; o_ready low during RUN.
//  5 rst asserted at step 8 -> no o_valid; outputs 0 next cycle; o_ready=1.
//    A new transaction then reproduces scenario 2 values.
//  6 i_valid pulsed during RUN -> ignored, single o_valid, result of first operands only.

Source files
------------

// File: rtl/delta_seq.sv
`default_nettype none
// ============================================================================
// Module      : delta_seq
// Description : LSTM back-propagation delta engine for one cell per
//               transaction. Computes dstate, d_a, d_i, d_f and d_o over 16
//               sequenced steps. The steps share one saturating fixed-point
//               multiplier and one saturating add/sub unit.
//
// Ports       : clk, rst           clock, synchronous active-high reset
//               i_valid / o_ready  operand handshake; o_ready in IDLE or DONE
//               i_last             1: output layer (Dout=h-t), 0: hidden (i_d_out)
//               i_at,i_it,i_ft,i_ot  gate activations at time t
//               i_tanh_s           tanh(state_t)
//               i_c_prev           state_{t-1}
//               i_h, i_t           output and label (output layer only)
//               i_d_out            Dout from upper layer (hidden layer only)
//               i_ds_next,i_f_next dstate_{t+1}, f_{t+1}
//               o_valid            one-cycle result strobe
//               o_d_state,o_d_a,o_d_i,o_d_f,o_d_o  published deltas
//               o_sat              any operation of the transaction clamped
// Revision    : 1.0 - initial release
// ============================================================================
module delta_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_at,
    input  logic [WIDTH-1:0] i_it,
    input  logic [WIDTH-1:0] i_ft,
    input  logic [WIDTH-1:0] i_ot,
    input  logic [WIDTH-1:0] i_tanh_s,
    input  logic [WIDTH-1:0] i_c_prev,
    input  logic [WIDTH-1:0] i_h,
    input  logic [WIDTH-1:0] i_t,
    input  logic [WIDTH-1:0] i_d_out,
    input  logic [WIDTH-1:0] i_ds_next,
    input  logic [WIDTH-1:0] i_f_next,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_d_state,
    output logic [WIDTH-1:0] o_d_a,
    output logic [WIDTH-1:0] o_d_i,
    output logic [WIDTH-1:0] o_d_f,
    output logic [WIDTH-1:0] o_d_o,
    output logic             o_sat
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0]       C_LAST_STEP = 5'd16;
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(64'd1 << FRAC);
    localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // FSM
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [4:0] r_step;
    logic       w_accept;

    // Captured operands
    logic             r_last;
    logic [WIDTH-1:0] r_op_at, r_op_it, r_op_ft, r_op_ot, r_op_tanh, r_op_c_prev;
    logic [WIDTH-1:0] r_op_h, r_op_t, r_op_d_out, r_op_ds_next, r_op_f_next;

    // Scratch: r_m[k] holds product Mk of the step schedule (M9 does not exist)
    logic [WIDTH-1:0] r_m [1:13];
    logic [WIDTH-1:0] r_a, r_b, r_c, r_d, r_e, r_f, r_ds;
    logic [WIDTH-1:0] r_do, r_da, r_di, r_df;
    logic             r_sat;

    // Published outputs
    logic             r_valid;
    logic [WIDTH-1:0] r_out_ds, r_out_da, r_out_di, r_out_df, r_out_do;
    logic             r_out_sat;

    // Shared arithmetic
    logic [WIDTH-1:0]          w_mul_a, w_mul_b, w_mul_res;
    logic                      w_mul_en, w_mul_ovf;
    logic signed [2*WIDTH-1:0] w_prod, w_shift;
    logic [WIDTH-1:0]          w_as_a, w_as_b, w_as_res;
    logic                      w_as_en, w_as_sub, w_as_ovf;
    logic [WIDTH:0]            w_as_sum;

    assign o_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = i_valid && o_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_step  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_step <= 5'd1;
            end else if (r_state == S_RUN) begin
                r_step <= r_step + 5'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_step == C_LAST_STEP) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier: full-width signed product, floor shift by FRAC, clamp.
    // The product of two sign-extended 2W operands is exact in 2W bits.
    // ------------------------------------------------------------------
    assign w_prod    = $signed({{WIDTH{w_mul_a[WIDTH-1]}}, w_mul_a}) *
                       $signed({{WIDTH{w_mul_b[WIDTH-1]}}, w_mul_b});
    assign w_shift   = w_prod >>> FRAC;
    // In range only if all bits above the result sign agree with it
    assign w_mul_ovf = !((&w_shift[2*WIDTH-1:WIDTH-1]) || !(|w_shift[2*WIDTH-1:WIDTH-1]));
    assign w_mul_res = w_mul_ovf ? (w_shift[2*WIDTH-1] ? C_MIN : C_MAX)
                                 : w_shift[WIDTH-1:0];

    // Add/sub: one guard bit, overflow when guard and sign disagree
    assign w_as_sum = w_as_sub ? ({w_as_a[WIDTH-1], w_as_a} - {w_as_b[WIDTH-1], w_as_b})
                               : ({w_as_a[WIDTH-1], w_as_a} + {w_as_b[WIDTH-1], w_as_b});
    assign w_as_ovf = w_as_sum[WIDTH] ^ w_as_sum[WIDTH-1];
    assign w_as_res = w_as_ovf ? (w_as_sum[WIDTH] ? C_MIN : C_MAX)
                               : w_as_sum[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Operand selection for the current step
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_a  = '0;
        w_mul_b  = '0;
        w_mul_en = 1'b0;
        w_as_a   = '0;
        w_as_b   = '0;
        w_as_sub = 1'b0;
        w_as_en  = 1'b0;
        if (r_state == S_RUN) begin
            w_mul_en = 1'b1;
            case (r_step)
                5'd1: begin
                    w_mul_a = r_op_tanh;  w_mul_b = r_op_tanh;
                    w_as_a  = r_op_h;     w_as_b  = r_op_t;  w_as_sub = 1'b1;
                    w_as_en = r_last;     // hidden layer passes d_out through
                end
                5'd2: begin
                    w_mul_a = r_a;  w_mul_b = r_op_ot;
                    w_as_a  = C_ONE; w_as_b = r_m[1]; w_as_sub = 1'b1; w_as_en = 1'b1;
                end
                5'd3:  begin w_mul_a = r_m[2];       w_mul_b = r_b;         end
                5'd4:  begin w_mul_a = r_op_ds_next; w_mul_b = r_op_f_next; end
                5'd5: begin
                    w_mul_a = r_a;    w_mul_b = r_op_tanh;
                    w_as_a  = r_m[3]; w_as_b  = r_m[4]; w_as_en = 1'b1;
                end
                5'd6: begin
                    w_mul_a = r_op_at; w_mul_b = r_op_at;
                    w_as_a  = C_ONE;   w_as_b  = r_op_ot; w_as_sub = 1'b1; w_as_en = 1'b1;
                end
                5'd7: begin
                    w_mul_a = r_m[5]; w_mul_b = r_op_ot;
                    w_as_a  = C_ONE;  w_as_b  = r_m[6]; w_as_sub = 1'b1; w_as_en = 1'b1;
                end
                5'd8: begin
                    w_mul_a = r_m[7]; w_mul_b = r_c;
                    w_as_a  = C_ONE;  w_as_b  = r_op_it; w_as_sub = 1'b1; w_as_en = 1'b1;
                end
                5'd9: begin
                    w_mul_a = r_ds;  w_mul_b = r_op_it;
                    w_as_a  = C_ONE; w_as_b  = r_op_ft; w_as_sub = 1'b1; w_as_en = 1'b1;
                end
                5'd10: begin w_mul_a = r_m[8];  w_mul_b = r_d;         end
                5'd11: begin w_mul_a = r_ds;    w_mul_b = r_op_at;     end
                5'd12: begin w_mul_a = r_m[10]; w_mul_b = r_op_it;     end
                5'd13: begin w_mul_a = r_m[11]; w_mul_b = r_e;         end
                5'd14: begin w_mul_a = r_ds;    w_mul_b = r_op_c_prev; end
                5'd15: begin w_mul_a = r_m[12]; w_mul_b = r_op_ft;     end
                5'd16: begin w_mul_a = r_m[13]; w_mul_b = r_f;         end
                default: w_mul_en = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
            {r_op_at, r_op_it, r_op_ft, r_op_ot, r_op_tanh, r_op_c_prev} <= '0;
            {r_op_h, r_op_t, r_op_d_out, r_op_ds_next, r_op_f_next}      <= '0;
            for (int k = 1; k <= 13; k++) r_m[k] <= '0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_ds} <= '0;
            {r_do, r_da, r_di, r_df}             <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            {r_out_ds, r_out_da, r_out_di, r_out_df, r_out_do} <= '0;
            r_out_sat <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Publish the finished transaction; a same-edge accept reads old values
            if (r_state == S_DONE) begin
                r_valid   <= 1'b1;
                r_out_ds  <= r_ds;
                r_out_da  <= r_da;
                r_out_di  <= r_di;
                r_out_df  <= r_df;
                r_out_do  <= r_do;
                r_out_sat <= r_sat;
            end

            if (w_accept) begin
                r_last        <= i_last;
                r_op_at       <= i_at;
                r_op_it       <= i_it;
                r_op_ft       <= i_ft;
                r_op_ot       <= i_ot;
                r_op_tanh     <= i_tanh_s;
                r_op_c_prev   <= i_c_prev;
                r_op_h        <= i_h;
                r_op_t        <= i_t;
                r_op_d_out    <= i_d_out;
                r_op_ds_next  <= i_ds_next;
                r_op_f_next   <= i_f_next;
                r_sat         <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_sat <= r_sat | (w_mul_en & w_mul_ovf) | (w_as_en & w_as_ovf);
                case (r_step)
                    5'd1: begin
                        r_a    <= r_last ? w_as_res : r_op_d_out;
                        r_m[1] <= w_mul_res;
                    end
                    5'd2:  begin r_m[2] <= w_mul_res; r_b  <= w_as_res; end
                    5'd3:  r_m[3] <= w_mul_res;
                    5'd4:  r_m[4] <= w_mul_res;
                    5'd5:  begin r_m[5] <= w_mul_res; r_ds <= w_as_res; end
                    5'd6:  begin r_m[6] <= w_mul_res; r_c  <= w_as_res; end
                    5'd7:  begin r_m[7] <= w_mul_res; r_d  <= w_as_res; end
                    5'd8:  begin r_do   <= w_mul_res; r_e  <= w_as_res; end
                    5'd9:  begin r_m[8] <= w_mul_res; r_f  <= w_as_res; end
                    5'd10: r_da    <= w_mul_res;
                    5'd11: r_m[10] <= w_mul_res;
                    5'd12: r_m[11] <= w_mul_res;
                    5'd13: r_di    <= w_mul_res;
                    5'd14: r_m[12] <= w_mul_res;
                    5'd15: r_m[13] <= w_mul_res;
                    5'd16: r_df    <= w_mul_res;
                    default: ;
                endcase
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_d_state = r_out_ds;
    assign o_d_a     = r_out_da;
    assign o_d_i     = r_out_di;
    assign o_d_f     = r_out_df;
    assign o_d_o     = r_out_do;
    assign o_sat     = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_delta_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_delta_seq
// Description : Self-checking bench for delta_seq (Q8.24). Directed cases
//               plus randomized transactions compared against an arithmetic
//               model of the delta equations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delta_seq;

    localparam logic [31:0] c_ONE  = 32'h0100_0000;
    localparam logic [31:0] c_HALF = 32'h0080_0000;

    typedef struct {
        logic        last;
        logic [31:0] at, it, ft, ot, tanh_s, c_prev, h, t, d_out, ds_next, f_next;
    } ops_t;

    typedef struct {
        logic [31:0] ds, da, di, df, d_o;
        logic        sat;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready, i_last, o_valid, o_sat;
    logic [31:0] i_at, i_it, i_ft, i_ot, i_tanh_s, i_c_prev, i_h, i_t, i_d_out;
    logic [31:0] i_ds_next, i_f_next;
    logic [31:0] o_d_state, o_d_a, o_d_i, o_d_f, o_d_o;

    int   n_vec = 0;
    int   n_err = 0;
    bit   m_sat;
    res_t obs;

    always #5 clk = ~clk;

    delta_seq #(.WIDTH(32), .FRAC(24)) u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
        .i_at(i_at), .i_it(i_it), .i_ft(i_ft), .i_ot(i_ot), .i_tanh_s(i_tanh_s),
        .i_c_prev(i_c_prev), .i_h(i_h), .i_t(i_t), .i_d_out(i_d_out),
        .i_ds_next(i_ds_next), .i_f_next(i_f_next), .o_valid(o_valid),
        .o_d_state(o_d_state), .o_d_a(o_d_a), .o_d_i(o_d_i), .o_d_f(o_d_f),
        .o_d_o(o_d_o), .o_sat(o_sat)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] clamp(input longint v);
        if (v > 64'sd2147483647) begin m_sat = 1'b1; return 32'h7FFF_FFFF; end
        if (v < -64'sd2147483648) begin m_sat = 1'b1; return 32'h8000_0000; end
        return v[31:0];
    endfunction

    function automatic logic [31:0] mmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return clamp(p >>> 24);
    endfunction

    function automatic logic [31:0] madd(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return clamp(sub ? sa - sb : sa + sb);
    endfunction

    function automatic res_t model(input ops_t o);
        res_t r;
        logic [31:0] dout, ds, dstate_gate, tanh_dr;
        m_sat = 1'b0;
        dout = o.last ? madd(o.h, o.t, 1'b1) : o.d_out;
        // dstate = Dout*o*(1-tanh^2) + ds_next*f_next
        dstate_gate = mmul(mmul(dout, o.ot), madd(c_ONE, mmul(o.tanh_s, o.tanh_s), 1'b1));
        tanh_dr     = mmul(o.ds_next, o.f_next);
        ds          = madd(dstate_gate, tanh_dr, 1'b0);
        r.d_o = mmul(mmul(mmul(dout, o.tanh_s), o.ot), madd(c_ONE, o.ot, 1'b1));
        r.da  = mmul(mmul(ds, o.it), madd(c_ONE, mmul(o.at, o.at), 1'b1));
        r.di  = mmul(mmul(mmul(ds, o.at), o.it), madd(c_ONE, o.it, 1'b1));
        r.df  = mmul(mmul(mmul(ds, o.c_prev), o.ft), madd(c_ONE, o.ft, 1'b1));
        r.ds  = ds;
        r.sat = m_sat;
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] r_frac();
        return 32'($urandom_range(0, 32'h0100_0000));
    endfunction

    function automatic logic [31:0] r_sgn();
        return 32'($urandom_range(0, 32'h0200_0000)) - c_ONE;
    endfunction

    function automatic ops_t rand_ops(input bit wild);
        ops_t o;
        o.last = 1'($urandom_range(0, 1));
        if (wild) begin
            o.at = $urandom(); o.it = $urandom(); o.ft = $urandom(); o.ot = $urandom();
            o.tanh_s = $urandom(); o.c_prev = $urandom(); o.h = $urandom(); o.t = $urandom();
            o.d_out = $urandom(); o.ds_next = $urandom(); o.f_next = $urandom();
        end else begin
            o.at = r_frac(); o.it = r_frac(); o.ft = r_frac(); o.ot = r_frac();
            o.tanh_s = r_sgn(); o.c_prev = r_sgn(); o.h = r_sgn(); o.t = r_sgn();
            o.d_out = r_sgn(); o.ds_next = r_sgn(); o.f_next = r_frac();
        end
        return o;
    endfunction

    task automatic drive(input ops_t o, input logic v);
        i_valid = v; i_last = o.last;
        i_at = o.at; i_it = o.it; i_ft = o.ft; i_ot = o.ot; i_tanh_s = o.tanh_s;
        i_c_prev = o.c_prev; i_h = o.h; i_t = o.t; i_d_out = o.d_out;
        i_ds_next = o.ds_next; i_f_next = o.f_next;
    endtask

    task automatic cmp_res(input string tag, input res_t e);
        obs.ds = o_d_state; obs.da = o_d_a; obs.di = o_d_i; obs.df = o_d_f;
        obs.d_o = o_d_o; obs.sat = o_sat;
        chk({tag, "_ds"},  o_d_state, e.ds);
        chk({tag, "_da"},  o_d_a,     e.da);
        chk({tag, "_di"},  o_d_i,     e.di);
        chk({tag, "_df"},  o_d_f,     e.df);
        chk({tag, "_do"},  o_d_o,     e.d_o);
        chk({tag, "_sat"}, o_sat,     e.sat);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; i_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    // One transaction; pulse_at>0 raises i_valid with junk for edges
    // pulse_at..pulse_at+2 while busy (must stay within the run phase).
    task automatic run_txn(input ops_t op, input int pulse_at, input string tag);
        res_t e;
        int   n, early, rdy_bad;
        e = model(op);
        @(negedge clk);
        drive(op, 1'b1);
        n = 0;
        while (o_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_ready_wait"}, n < 40, 1'b1);
        @(posedge clk); #1;
        drive(rand_ops(1'b1), 1'b0);
        early = 0; rdy_bad = 0;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k < 17) begin
                if (o_valid !== 1'b0) early++;
                if (o_ready !== (k == 16)) rdy_bad++;
            end
            drive(rand_ops(1'b1), (pulse_at > 0 && k + 1 >= pulse_at && k + 1 < pulse_at + 3));
        end
        chk({tag, "_early_valid"}, early, 0);
        chk({tag, "_ready_busy"}, rdy_bad, 0);
        chk({tag, "_valid17"}, o_valid, 1'b1);
        cmp_res(tag, e);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, o_valid, 1'b0);
    endtask

    ops_t op2, op3, s1, s2;
    res_t e1, e2;

    initial begin
        int bad;
        rst = 1'b1;
        drive(rand_ops(1'b0), 1'b0);
        do_reset();

        // Reset then idle
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("idle_ctl", {o_ready, o_valid, o_sat}, 3'b100);
            chk("idle_out", o_d_state | o_d_a | o_d_i | o_d_f | o_d_o, 32'h0);
        end

        // Output-layer directed case
        op2.last = 1'b1; op2.h = 32'h00C0_0000; op2.t = c_ONE;
        op2.tanh_s = c_HALF; op2.at = c_HALF; op2.it = c_HALF; op2.ft = c_HALF; op2.ot = c_HALF;
        op2.c_prev = c_ONE; op2.ds_next = 32'h0; op2.f_next = 32'h0; op2.d_out = 32'h1234_5678;
        run_txn(op2, 0, "out_layer");
        chk("s2_ds",  obs.ds,  32'hFFE8_0000);
        chk("s2_do",  obs.d_o, 32'hFFF8_0000);
        chk("s2_da",  obs.da,  32'hFFF7_0000);
        chk("s2_di",  obs.di,  32'hFFFD_0000);
        chk("s2_df",  obs.df,  32'hFFFA_0000);
        chk("s2_sat", obs.sat, 1'b0);

        // Hidden-layer saturation case
        op3 = rand_ops(1'b0);
        op3.last = 1'b0; op3.d_out = 32'h4000_0000; op3.ot = c_ONE; op3.tanh_s = 32'h0;
        op3.ds_next = 32'h4000_0000; op3.f_next = 32'h4000_0000;
        run_txn(op3, 0, "hid_sat");
        chk("s3_ds",  obs.ds,  32'h7FFF_FFFF);
        chk("s3_sat", obs.sat, 1'b1);

        // Back-to-back with i_valid held high
        s1 = rand_ops(1'b0); s2 = rand_ops(1'b0);
        e1 = model(s1); e2 = model(s2);
        @(negedge clk); drive(s1, 1'b1);
        @(posedge clk); #1; drive(s2, 1'b1);
        bad = 0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k != 17 && k != 34 && o_valid !== 1'b0) bad++;
            if (o_ready !== (k == 16 || k == 33)) bad++;
            if (k == 17) begin
                chk("b2b_v1", o_valid, 1'b1);
                cmp_res("b2b_1", e1);
                drive(rand_ops(1'b1), 1'b1);
            end
            if (k == 34) begin
                chk("b2b_v2", o_valid, 1'b1);
                cmp_res("b2b_2", e2);
                i_valid = 1'b0;
            end
        end
        chk("b2b_ctl", bad, 0);
        do_reset();

        // Abort at step 8
        @(negedge clk); drive(op2, 1'b1);
        @(posedge clk); #1; i_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        chk("abort_ctl", {o_ready, o_valid, o_sat}, 3'b100);
        chk("abort_out", o_d_state | o_d_a | o_d_i | o_d_f | o_d_o, 32'h0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b0) bad++;
        end
        chk("abort_no_valid", bad, 0);
        run_txn(op2, 0, "after_abort");
        chk("s5_ds", obs.ds, 32'hFFE8_0000);
        chk("s5_di", obs.di, 32'hFFFD_0000);

        // i_valid pulses while busy are ignored
        run_txn(rand_ops(1'b0), 5, "busy_pulse");
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b0) bad++;
        end
        chk("busy_pulse_single", bad, 0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_txn(rand_ops($urandom_range(0, 3) == 0), 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
